// File: rtl/cpu_muldiv_pkg.sv
// Shared constants for the multi-cycle mul/div sequencer: opcodes, FSM states, op decode.
package cpu_muldiv_pkg;

   localparam int ITER_DEF  = 32;
   localparam int CNT_W_DEF = 6;

   localparam logic [5:0] OP_MUL_L  = 6'h2f;
   localparam logic [5:0] OP_DIV_L  = 6'h31;
   localparam logic [5:0] OP_UDIV_L = 6'h32;
   localparam logic [5:0] OP_MOD_L  = 6'h33;
   localparam logic [5:0] OP_UMOD_L = 6'h34;

   typedef enum logic [1:0] {
      MULDIV_IDLE = 2'd0,
      MULDIV_RUN  = 2'd1,
      MULDIV_DONE = 2'd2
   } muldiv_state_e;

   typedef enum logic [2:0] {
      MOP_NONE = 3'd0,
      MOP_MUL  = 3'd1,
      MOP_DIV  = 3'd2,
      MOP_UDIV = 3'd3,
      MOP_MOD  = 3'd4,
      MOP_UMOD = 3'd5
   } mop_e;

   function automatic mop_e decode_op(input logic [5:0] op);
      case (op)
         OP_MUL_L:  return MOP_MUL;
         OP_DIV_L:  return MOP_DIV;
         OP_UDIV_L: return MOP_UDIV;
         OP_MOD_L:  return MOP_MOD;
         OP_UMOD_L: return MOP_UMOD;
         default:   return MOP_NONE;
      endcase
   endfunction

endpackage

// File: rtl/cpu_muldiv_seq_div_step.sv
// One restoring-divide iteration: shift the next dividend bit into the remainder, trial-subtract.
module cpu_div_step (
   input  logic [31:0] rem_i,
   input  logic [31:0] quo_i,
   input  logic [31:0] div_i,
   output logic [31:0] rem_o,
   output logic        q_bit_o
);

   logic [32:0] rem_sh;
   logic [33:0] diff;

   always_comb begin
      rem_sh  = {rem_i, quo_i[31]};
      diff    = {1'b0, rem_sh} - {2'b00, div_i};
      q_bit_o = ~diff[33];
      // remainder stays below the divisor, so the kept value always fits in 32 bits
      rem_o   = q_bit_o ? diff[31:0] : rem_sh[31:0];
   end

endmodule

// File: rtl/cpu_muldiv_seq.sv
// Multi-cycle MUL_L / DIV_L / UDIV_L / MOD_L / UMOD_L sequencer beside execute.
// Optional: MOXIE_FAST_MUL_EN makes MUL_L a single-cycle multiply (IDLE -> DONE).
module cpu_muldiv_seq
   import cpu_muldiv_pkg::*;
#(
   parameter int ITER  = ITER_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        flush_i,
   input  logic        start_i,
   input  logic [5:0]  op_i,
   input  logic [31:0] regA_i,
   input  logic [31:0] regB_i,
   input  logic [3:0]  dest_index_i,
   output logic        stall_o,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] result_o,
   output logic [3:0]  result_index_o,
   output logic        div_by_zero_o
);

   muldiv_state_e    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   mop_e             mop_q, mop_d;
   logic [3:0]       idx_q, idx_d;
   logic [31:0]      opnd_q, opnd_d;   // dividend->quotient shift reg, or multiplier
   logic [31:0]      dvs_q, dvs_d;     // divisor, or multiplicand
   logic [31:0]      acc_q, acc_d;     // partial remainder, or product
   logic             negq_q, negq_d;
   logic             negr_q, negr_d;
   logic             dz_q, dz_d;
   logic [31:0]      result_q, result_d;
   logic             busy_q, busy_d;

   mop_e        in_mop;
   logic        in_signed, in_div, accept;
   logic [31:0] a_mag, b_mag;
   logic [31:0] step_rem, mul_acc, next_acc, next_opnd;
   logic        step_qbit, is_mul;
   logic [31:0] quo_fix, rem_fix;

   cpu_div_step u_step (
      .rem_i   (acc_q),
      .quo_i   (opnd_q),
      .div_i   (dvs_q),
      .rem_o   (step_rem),
      .q_bit_o (step_qbit)
   );

   always_comb begin
      in_mop    = decode_op(op_i);
      in_signed = (in_mop == MOP_DIV) | (in_mop == MOP_MOD);
      in_div    = (in_mop != MOP_NONE) & (in_mop != MOP_MUL);
      accept    = (state_q == MULDIV_IDLE) & start_i & ~flush_i & (in_mop != MOP_NONE);
      a_mag     = (in_signed & regA_i[31]) ? -regA_i : regA_i;
      b_mag     = (in_signed & regB_i[31]) ? -regB_i : regB_i;

      // shift-add consumes the multiplier MSB first; only the low 32 product bits are kept
      is_mul    = (mop_q == MOP_MUL);
      mul_acc   = {acc_q[30:0], 1'b0} + (opnd_q[31] ? dvs_q : 32'd0);
      next_acc  = is_mul ? mul_acc : step_rem;
      next_opnd = {opnd_q[30:0], is_mul ? 1'b0 : step_qbit};

      quo_fix   = dz_q ? 32'hFFFF_FFFF : (negq_q ? -next_opnd : next_opnd);
      rem_fix   = negr_q ? -next_acc : next_acc;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mop_d    = mop_q;
      idx_d    = idx_q;
      opnd_d   = opnd_q;
      dvs_d    = dvs_q;
      acc_d    = acc_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      dz_d     = dz_q;
      result_d = result_q;

      case (state_q)
         MULDIV_IDLE: begin
            if (accept) begin
               mop_d  = in_mop;
               idx_d  = dest_index_i;
               acc_d  = 32'd0;
               negq_d = in_signed & (regA_i[31] ^ regB_i[31]);
               negr_d = in_signed & regA_i[31];
               dz_d   = in_div & (regB_i == 32'd0);
               if (in_mop == MOP_MUL) begin
                  opnd_d = regB_i;
                  dvs_d  = regA_i;
               end else begin
                  opnd_d = a_mag;
                  dvs_d  = b_mag;
               end
`ifdef MOXIE_FAST_MUL_EN
               if (in_mop == MOP_MUL) begin
                  result_d = regA_i * regB_i;
                  state_d  = MULDIV_DONE;
               end else begin
                  cnt_d   = CNT_W'(ITER);
                  state_d = MULDIV_RUN;
               end
`else
               cnt_d   = CNT_W'(ITER);
               state_d = MULDIV_RUN;
`endif
            end
         end
         MULDIV_RUN: begin
            acc_d  = next_acc;
            opnd_d = next_opnd;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               case (mop_q)
                  MOP_MUL:            result_d = next_acc;
                  MOP_DIV, MOP_UDIV:  result_d = quo_fix;
                  default:            result_d = rem_fix;
               endcase
               state_d = MULDIV_DONE;
            end
            if (flush_i) state_d = MULDIV_IDLE;
         end
         MULDIV_DONE: state_d = MULDIV_IDLE;
         default:     state_d = MULDIV_IDLE;
      endcase
   end

   assign busy_d = (state_d != MULDIV_IDLE);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= MULDIV_IDLE;
         cnt_q    <= '0;
         mop_q    <= MOP_NONE;
         idx_q    <= '0;
         opnd_q   <= '0;
         dvs_q    <= '0;
         acc_q    <= '0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         dz_q     <= 1'b0;
         result_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mop_q    <= mop_d;
         idx_q    <= idx_d;
         opnd_q   <= opnd_d;
         dvs_q    <= dvs_d;
         acc_q    <= acc_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         dz_q     <= dz_d;
         result_q <= result_d;
         busy_q   <= busy_d;
      end
   end

   assign stall_o        = accept | (state_q == MULDIV_RUN) | ((state_q == MULDIV_DONE) & start_i);
   assign busy_o         = busy_q;
   assign done_o         = (state_q == MULDIV_DONE) & ~flush_i;
   assign div_by_zero_o  = done_o & dz_q;
   assign result_o       = result_q;
   assign result_index_o = idx_q;

endmodule

// File: tb/tb_cpu_muldiv_seq.sv
// Directed checks of cpu_muldiv_seq: arithmetic, latency, divide-by-zero, flush and reset.
module tb_cpu_muldiv_seq;
   import cpu_muldiv_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        flush_i = 1'b0;
   logic        start_i = 1'b0;
   logic [5:0]  op_i = '0;
   logic [31:0] regA_i = '0;
   logic [31:0] regB_i = '0;
   logic [3:0]  dest_index_i = '0;
   logic        stall_o, busy_o, done_o, div_by_zero_o;
   logic [31:0] result_o;
   logic [3:0]  result_index_o;

   int n_chk  = 0;
   int n_fail = 0;

`ifdef MOXIE_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif

   cpu_muldiv_seq dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .flush_i        (flush_i),
      .start_i        (start_i),
      .op_i           (op_i),
      .regA_i         (regA_i),
      .regB_i         (regB_i),
      .dest_index_i   (dest_index_i),
      .stall_o        (stall_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .result_o       (result_o),
      .result_index_o (result_index_o),
      .div_by_zero_o  (div_by_zero_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive_start(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] idx);
      @(posedge clk_i); #1;
      start_i = 1'b1; op_i = op; regA_i = a; regB_i = b; dest_index_i = idx;
   endtask

   task automatic do_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] idx, input logic [31:0] exp_res,
                        input logic exp_dz, input int exp_lat);
      int lat;
      logic [31:0] res;
      logic dz;
      logic [3:0] ix;
      lat = 0; res = '0; dz = 1'b0; ix = '0;
      drive_start(op, a, b, idx);
      @(negedge clk_i);
      chk({tag, "_stall"}, 32'(stall_o), 32'd1);
      @(posedge clk_i); #1;
      start_i = 1'b0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk_i);
         if (done_o) begin
            lat = i; res = result_o; dz = div_by_zero_o; ix = result_index_o;
            break;
         end
         @(posedge clk_i); #1;
      end
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_res"}, res, exp_res);
      chk({tag, "_dz"}, 32'(dz), 32'(exp_dz));
      chk({tag, "_idx"}, 32'(ix), 32'(idx));
      @(posedge clk_i); #1;
   endtask

   initial begin
      int dones;
      #2;
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_res", result_o, 32'd0);
      chk("rst_idx", 32'(result_index_o), 32'd0);
      chk("rst_dz", 32'(div_by_zero_o), 32'd0);
      @(negedge clk_i); rst_i = 1'b0;

      do_op("udiv", OP_UDIV_L, 32'd100, 32'd7, 4'd3, 32'd14, 1'b0, 33);
      do_op("umod", OP_UMOD_L, 32'd100, 32'd7, 4'd4, 32'd2, 1'b0, 33);
      do_op("sdiv", OP_DIV_L, 32'hFFFF_FF9C, 32'd7, 4'd5, 32'hFFFF_FFF2, 1'b0, 33);
      do_op("smod", OP_MOD_L, 32'hFFFF_FF9C, 32'd7, 4'd6, 32'hFFFF_FFFE, 1'b0, 33);
      do_op("sdivnb", OP_DIV_L, 32'd100, 32'hFFFF_FFF9, 4'd7, 32'hFFFF_FFF2, 1'b0, 33);
      do_op("smodnb", OP_MOD_L, 32'd100, 32'hFFFF_FFF9, 4'd8, 32'd2, 1'b0, 33);
      do_op("udz", OP_UDIV_L, 32'd5, 32'd0, 4'd9, 32'hFFFF_FFFF, 1'b1, 33);
      do_op("umdz", OP_UMOD_L, 32'd5, 32'd0, 4'd10, 32'd5, 1'b1, 33);
      do_op("smdz", OP_MOD_L, 32'hFFFF_FFFB, 32'd0, 4'd11, 32'hFFFF_FFFB, 1'b1, 33);
      do_op("ovf", OP_DIV_L, 32'h8000_0000, 32'hFFFF_FFFF, 4'd12, 32'h8000_0000, 1'b0, 33);
      do_op("ovfm", OP_MOD_L, 32'h8000_0000, 32'hFFFF_FFFF, 4'd13, 32'd0, 1'b0, 33);
      do_op("mul", OP_MUL_L, 32'h0001_0000, 32'h0001_0003, 4'd14, 32'h0003_0000, 1'b0, MUL_LAT);
      do_op("muln", OP_MUL_L, 32'd7, 32'hFFFF_FFFD, 4'd15, 32'hFFFF_FFEB, 1'b0, MUL_LAT);

      // unknown opcode must not start anything
      drive_start(6'h00, 32'd1, 32'd1, 4'd1);
      @(negedge clk_i);
      chk("badop_stall", 32'(stall_o), 32'd0);
      @(posedge clk_i); #1; start_i = 1'b0;
      @(negedge clk_i);
      chk("badop_busy", 32'(busy_o), 32'd0);

      // flush in cycle 10 aborts the op
      drive_start(OP_DIV_L, 32'd1000, 32'd3, 4'd2);
      @(posedge clk_i); #1; start_i = 1'b0;
      repeat (9) begin @(posedge clk_i); #1; end
      flush_i = 1'b1;
      @(posedge clk_i); #1; flush_i = 1'b0;
      @(negedge clk_i);
      chk("flush_busy", 32'(busy_o), 32'd0);
      chk("flush_stall", 32'(stall_o), 32'd0);
      dones = 0;
      repeat (40) begin @(negedge clk_i); if (done_o) dones++; end
      chk("flush_nodone", 32'(dones), 32'd0);
      do_op("postflush", OP_UDIV_L, 32'd1000, 32'd3, 4'd2, 32'd333, 1'b0, 33);

      // asynchronous reset mid-op
      drive_start(OP_UDIV_L, 32'd50, 32'd0, 4'd9);
      @(posedge clk_i); #1; start_i = 1'b0;
      repeat (5) begin @(posedge clk_i); end
      #2; rst_i = 1'b1; #1;
      chk("mrst_busy", 32'(busy_o), 32'd0);
      chk("mrst_done", 32'(done_o), 32'd0);
      chk("mrst_res", result_o, 32'd0);
      chk("mrst_idx", 32'(result_index_o), 32'd0);
      chk("mrst_stall", 32'(stall_o), 32'd0);
      @(negedge clk_i); rst_i = 1'b0;
      dones = 0;
      repeat (40) begin @(negedge clk_i); if (done_o) dones++; end
      chk("mrst_nodone", 32'(dones), 32'd0);
      do_op("postrst", OP_UMOD_L, 32'd1000, 32'd3, 4'd6, 32'd1, 1'b0, 33);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
